limb_accumulator: RTL
=====================

# limb_accumulator

Downstream stage of the constant-operand Karatsuba multiplier (constKaratsuba). It consumes that multiplier's stream of 384-bit partial products X·Y_i, where Y_i is the i-th 128-bit limb of a wide operand Y, fed least-significant limb first. It recombines them into the full product X·Y = Σ P_i·2^(128·i) using a running carry window and a single 385-bit adder per beat. It presents the result with a one-cycle valid pulse to the reduction stage.

## Interface
- NUM_LIMBS, 2, limbs of Y per operand (≥2); output width ZW = CONST_W + LIMB_W·NUM_LIMBS (512 at defaults)
- CONST_W, 256, width of the constant operand X
- LIMB_W, 128, width of one Y limb; P width PW = CONST_W + LIMB_W (384)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- P  in  PW  partial product X·Y_i from the multiplier
- in_valid  in  1  P is valid this cycle (the multiplier's out_valid)
- clear  in  1  synchronous abort of a partially accumulated operand
- Z  out  ZW  full product, held until the next completion
- out_valid  out  1  one-cycle pulse: Z updated this cycle
- busy  out  1  at least one limb of the current operand accepted, last not yet

## Operation
- State: limb counter idx (0..NUM_LIMBS-1), carry window W (CONST_W+1 bits), working register R (ZW bits), output register Z.
- Accepted beat: in_valid=1 and clear=0. Compute S = P + W, where S is PW+1 bits wide and W is zero-extended.
- Non-last beat (idx < NUM_LIMBS-1):
  - R[LIMB_W·idx +: LIMB_W] ← S[LIMB_W-1:0]
  - W ← S[PW:LIMB_W]
  - idx ← idx+1
- Last beat (idx = NUM_LIMBS-1):
  - Z ← R with bits [LIMB_W·idx +: PW] replaced by S[PW-1:0]. S[PW] is discarded, so the result is mod 2^ZW. No discard occurs for in-range inputs (P ≤ (2^CONST_W−1)(2^LIMB_W−1)).
  - out_valid ← 1
  - idx ← 0, W ← 0
- No accepted beat: state holds and out_valid ← 0. Idle gaps between limbs of one operand are allowed and unbounded.
- clear=1: idx ← 0, W ← 0, out_valid ← 0. Z is unchanged. clear has priority over in_valid; a beat in the same cycle is dropped.
- busy = (idx ≠ 0), combinational from state.
- R contents for limbs not yet written are don't-care. Z never exposes a partially built product.
- No backpressure, because the upstream multiplier has no ready. One beat per cycle is always accepted.

## Timing
- Reset values: Z=0, out_valid=0, busy=0, idx=0, W=0, R=0.
- Latency: out_valid is high in the cycle after the edge that samples the last limb. Equivalently, it is registered on that same edge.
- Throughput: one operand per NUM_LIMBS cycles. A new operand's first limb may arrive on the edge immediately after the previous last limb.
- Back-to-back operands give out_valid pulses NUM_LIMBS cycles apart. Z is stable between pulses.
- Reset asserted mid-operand: all state returns to reset values at once; a partial operand is lost. After release, the next beat is limb 0.
- The critical path is one PW+1-bit add plus write muxing. No multi-cycle paths.

## Test plan
All scenarios use NUM_LIMBS=2, with beats applied at consecutive edges unless stated.

- Simple recombination: beats P=1, P=1 → out_valid one cycle after the 2nd beat; Z = 2^128 + 1; busy high only between the beats.
- Carry propagation: beats P=2^384−1, P=1 → Z = 2^384 + 2^128 − 1 (Z[127:0] all ones, Z[383:128]=0, Z[384]=1).
- Gaps: beat P=1, three idle cycles, beat P=1 → same Z as the simple case; busy high for all four cycles between the beats; no spurious out_valid.
- Back-to-back: four beats (1,1,2,3) at edges t..t+3 → out_valid pulses after t+1 and t+3; Z = 2^128+1, then 3·2^128+2; Z holds in between.
- clear and reset:
  - beat 5, then clear → busy drops.
  - beats 7, 9 → Z = 9·2^128 + 7.
  - clear together with in_valid → beat ignored.
  - reset after one beat → Z=0, out_valid=0, busy=0; the next two beats form a fresh product.
- End-to-end with constKaratsuba:
  - Fixed X = 92e5…13a2; feed Y limbs lo/hi for Y = 0, Y = 2^256−1, and 10 random values.
  - Check each Z against a reference X·Y computed in the bench.
  - Check one out_valid pulse per pair.

Source files
------------

// File: rtl/limb_accumulator.sv
// Recombines a stream of X*Y_i partial products (least-significant limb first)
// into the full product X*Y using a carry window and one PW+1-bit add per beat.
module limb_accumulator #(
  parameter int NUM_LIMBS = 2,
  parameter int CONST_W   = 256,
  parameter int LIMB_W    = 128,
  localparam int PW       = CONST_W + LIMB_W,
  localparam int ZW       = CONST_W + LIMB_W * NUM_LIMBS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [PW-1:0] P,
  input  logic          in_valid,
  input  logic          clear,
  output logic [ZW-1:0] Z,
  output logic          out_valid,
  output logic          busy
);

  localparam int IDX_W = (NUM_LIMBS > 2) ? $clog2(NUM_LIMBS) : 1;
  localparam int RW    = LIMB_W * (NUM_LIMBS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  logic [IDX_W-1:0]   idx;
  logic [CONST_W:0]   win;
  logic [RW-1:0]      r;
  logic [PW:0]        sum;
  logic               accept;
  logic               last;

  assign accept = in_valid && !clear;
  assign last   = (idx == LAST_IDX);
  assign sum    = {1'b0, P} + (PW + 1)'(win);
  assign busy   = (idx != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      win       <= '0;
      r         <= '0;
      Z         <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      idx       <= '0;
      win       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (last) begin
        // The final limb's window spans the top PW bits of Z exactly; S[PW] falls off.
        Z         <= {sum[PW-1:0], r};
        out_valid <= 1'b1;
        idx       <= '0;
        win       <= '0;
      end else begin
        for (int k = 0; k < NUM_LIMBS - 1; k++) begin
          if (idx == IDX_W'(k)) r[k*LIMB_W +: LIMB_W] <= sum[LIMB_W-1:0];
        end
        win       <= sum[PW:LIMB_W];
        idx       <= idx + 1'b1;
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
